// File: rtl/brq_arb_pkg.sv
// rtl/brq_arb_pkg.sv - shared types and helpers for the DCCM arbiter
//
// Purpose: master-index and grant types, the registered arbiter state, and
//          the round-robin index increment used by the picker.
// Ports:   none (package).
package brq_arb_pkg;

  localparam int MAX_MASTERS = 4;

  // Index of a requesting master (wide enough for MAX_MASTERS).
  typedef logic [1:0] mst_idx_t;

  // Grant vector at the widest supported configuration.
  typedef logic [MAX_MASTERS-1:0] gnt_vec_t;

  // Registered arbiter state: round-robin pointer plus the read that is
  // waiting for its data to come back from the DCCM.
  typedef struct packed {
    mst_idx_t last_gnt;
    logic     rd_pend;
    mst_idx_t rd_idx;
  } arb_state_t;

  // Next index in round-robin order, wrapping at n.
  function automatic mst_idx_t rr_next(input mst_idx_t idx, input int n);
    if (int'(idx) + 1 >= n) begin
      return '0;
    end
    return idx + mst_idx_t'(1);
  endfunction

endpackage

// File: rtl/brq_rr_picker.sv
// rtl/brq_rr_picker.sv - combinational round-robin request picker
//
// Purpose: picks one requester, starting the search at the master after
//          last_idx and wrapping at NumMasters.
// Ports:   req       - request vector, one bit per master
//          last_idx  - index of the most recently granted master
//          gnt       - one-hot grant (all zero when nobody requests)
//          gnt_idx   - index of the granted master (0 when no grant)
//          gnt_valid - a grant was made
module brq_rr_picker
  import brq_arb_pkg::*;
#(
  parameter int NumMasters = 2
) (
  input  logic [NumMasters-1:0] req,
  input  mst_idx_t              last_idx,
  output logic [NumMasters-1:0] gnt,
  output mst_idx_t              gnt_idx,
  output logic                  gnt_valid
);

  mst_idx_t cand;

  // Walk candidates in priority order; the first requesting one wins.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = rr_next(last_idx, NumMasters);
    for (int k = 0; k < NumMasters; k++) begin
      for (int i = 0; i < NumMasters; i++) begin
        if (!gnt_valid && (mst_idx_t'(i) == cand) && req[i]) begin
          gnt[i]    = 1'b1;
          gnt_idx   = cand;
          gnt_valid = 1'b1;
        end
      end
      cand = rr_next(cand, NumMasters);
    end
  end

endmodule

// File: rtl/brq_dmem_arbiter.sv
// rtl/brq_dmem_arbiter.sv - round-robin arbiter of several masters onto one DCCM port
//
// Purpose: grants one master per cycle, forwards its request to the DCCM in
//          the grant cycle and returns read data one cycle later.
//          Optional grant locking is built only when BRQ_ARB_LOCK_EN is defined.
// Ports:   brq_clk, brq_rst     - clock, asynchronous active-high reset
//          m_req/m_we/m_lock    - per-master request, write select, lock
//          m_addr/m_wdata/m_be  - per-master fields, master i at slice i
//          m_gnt                - one-hot combinational grant
//          m_rvalid, m_rdata    - read response (rdata shared, 0 when idle)
//          mem_*                - DCCM request; mem_rdata valid the cycle after mem_read_en
module brq_dmem_arbiter
  import brq_arb_pkg::*;
#(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 15,
  parameter int NumMasters = 2
) (
  input  logic                                brq_clk,
  input  logic                                brq_rst,
  input  logic [NumMasters-1:0]               m_req,
  input  logic [NumMasters-1:0]               m_we,
  input  logic [NumMasters*AddrWidth-1:0]     m_addr,
  input  logic [NumMasters*DataWidth-1:0]     m_wdata,
  input  logic [NumMasters*(DataWidth/8)-1:0] m_be,
  input  logic [NumMasters-1:0]               m_lock,
  output logic [NumMasters-1:0]               m_gnt,
  output logic [NumMasters-1:0]               m_rvalid,
  output logic [DataWidth-1:0]                m_rdata,
  output logic                                mem_read_en,
  output logic                                mem_write_en,
  output logic [AddrWidth-1:0]                mem_addr,
  output logic [DataWidth-1:0]                mem_wdata,
  output logic [DataWidth/8-1:0]              mem_be,
  input  logic [DataWidth-1:0]                mem_rdata
);

  localparam int BeWidth = DataWidth / 8;

  arb_state_t state_q;

  logic [NumMasters-1:0] eff_req;
  logic [NumMasters-1:0] pick_gnt;
  mst_idx_t              pick_idx;
  logic                  pick_valid;
  logic                  gnt_any;

  logic                  sel_we;
  logic [AddrWidth-1:0]  sel_addr;
  logic [DataWidth-1:0]  sel_wdata;
  logic [BeWidth-1:0]    sel_be;

`ifdef BRQ_ARB_LOCK_EN
  logic     lock_q;
  mst_idx_t lock_owner_q;
  logic     owner_req;
  logic     sel_lock;

  always_comb begin
    owner_req = 1'b0;
    sel_lock  = 1'b0;
    for (int i = 0; i < NumMasters; i++) begin
      if (mst_idx_t'(i) == lock_owner_q) begin
        owner_req = m_req[i];
      end
      if (pick_gnt[i]) begin
        sel_lock = m_lock[i];
      end
    end
  end

  // A lock only masks the others while its owner keeps requesting; the cycle
  // the owner drops m_req everyone competes again.
  always_comb begin
    eff_req = m_req;
    if (lock_q && owner_req) begin
      for (int i = 0; i < NumMasters; i++) begin
        eff_req[i] = m_req[i] && (mst_idx_t'(i) == lock_owner_q);
      end
    end
  end

  always_ff @(posedge brq_clk or posedge brq_rst) begin
    if (brq_rst) begin
      lock_q       <= 1'b0;
      lock_owner_q <= '0;
    end else if (gnt_any) begin
      lock_q       <= sel_lock;
      lock_owner_q <= pick_idx;
    end else if (lock_q && !owner_req) begin
      lock_q <= 1'b0;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^m_lock;
  assign eff_req     = m_req;
`endif

  brq_rr_picker #(
    .NumMasters(NumMasters)
  ) u_picker (
    .req      (eff_req),
    .last_idx (state_q.last_gnt),
    .gnt      (pick_gnt),
    .gnt_idx  (pick_idx),
    .gnt_valid(pick_valid)
  );

  // Reset masks the grant combinationally so nothing is accepted while it is
  // held, including a read that would otherwise complete after release.
  assign gnt_any = pick_valid && !brq_rst;
  assign m_gnt   = brq_rst ? '0 : pick_gnt;

  // Mux driven by the one-hot grant: no grant leaves every field at zero.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int i = 0; i < NumMasters; i++) begin
      if (m_gnt[i]) begin
        sel_we    = m_we[i];
        sel_addr  = m_addr[i*AddrWidth +: AddrWidth];
        sel_wdata = m_wdata[i*DataWidth +: DataWidth];
        sel_be    = m_be[i*BeWidth +: BeWidth];
      end
    end
  end

  assign mem_read_en  = gnt_any && !sel_we;
  assign mem_write_en = gnt_any && sel_we;
  assign mem_addr     = sel_addr;
  assign mem_wdata    = sel_wdata;
  assign mem_be       = sel_be;

  always_ff @(posedge brq_clk or posedge brq_rst) begin
    if (brq_rst) begin
      state_q.last_gnt <= mst_idx_t'(NumMasters - 1);
      state_q.rd_pend  <= 1'b0;
      state_q.rd_idx   <= '0;
    end else begin
      state_q.rd_pend <= mem_read_en;
      if (gnt_any) begin
        state_q.last_gnt <= pick_idx;
        state_q.rd_idx   <= pick_idx;
      end
    end
  end

  // Read response: the DCCM returns data exactly one cycle after the grant.
  always_comb begin
    m_rvalid = '0;
    for (int i = 0; i < NumMasters; i++) begin
      m_rvalid[i] = state_q.rd_pend && (state_q.rd_idx == mst_idx_t'(i));
    end
  end

  assign m_rdata = state_q.rd_pend ? mem_rdata : '0;

endmodule
